// File: rtl/div_monitor.sv
// Watches a divided clock (clk1_in) and its trigger pulse against expected timing in clk50
// cycles. It locks onto a good source and flags period, pulse, missing-pulse and stall faults.
module div_monitor #(
    parameter int unsigned HALF_PERIOD  = 35_000_001,
    parameter int unsigned PULSE_OFFSET = 25_000_001,
    parameter int unsigned TOL          = 0,
    localparam int unsigned W           = $clog2(HALF_PERIOD + TOL + 2)
) (
    input  logic         clk50,
    input  logic         rst,
    input  logic         clk1_in,
    input  logic         pulse_in,
    output logic         locked,
    output logic         clk1_edge,
    output logic [W-1:0] half_period_meas,
    output logic         period_err,
    output logic         pulse_err,
    output logic         miss_err,
    output logic         stall_err,
    output logic [7:0]   err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [W-1:0] SAT = W'(HALF_PERIOD + TOL + 1);

    state_t       state_q, state_d;
    logic         clk1_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         seen_q, seen_d;
    logic         locked_q, locked_d;
    logic         edge_q, edge_d;
    logic [W-1:0] meas_q, meas_d;
    logic         period_err_q, period_err_d;
    logic         pulse_err_q, pulse_err_d;
    logic         miss_err_q, miss_err_d;
    logic         stall_err_q, stall_err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic         edge_c;

    function automatic logic within_tol(input logic [W-1:0] value, input int unsigned target);
        logic [31:0] v;
        v = 32'(value);
        return (v + TOL >= target) && (v <= target + TOL);
    endfunction

    always_comb begin
        edge_c       = clk1_in ^ clk1_q;
        state_d      = state_q;
        seen_d       = seen_q;
        meas_d       = meas_q;
        period_err_d = 1'b0;
        pulse_err_d  = 1'b0;
        miss_err_d   = 1'b0;
        stall_err_d  = 1'b0;

        if (edge_c)
            cnt_d = W'(1);
        else if (cnt_q == SAT)
            cnt_d = SAT;
        else
            cnt_d = cnt_q + W'(1);

        // cnt_q is both the measured interval on an edge cycle and the pulse offset otherwise
        case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (edge_c)
                    state_d = ACQ;
            end
            ACQ: begin
                seen_d = 1'b0;
                if (edge_c) begin
                    meas_d = cnt_q;
                    if (within_tol(cnt_q, HALF_PERIOD))
                        state_d = LOCKED;
                end else if (cnt_d == SAT) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (pulse_in && (seen_q || !within_tol(cnt_q, PULSE_OFFSET)))
                    pulse_err_d = 1'b1;
                if (edge_c) begin
                    meas_d = cnt_q;
                    seen_d = 1'b0;
                    if (!(seen_q || pulse_in))
                        miss_err_d = 1'b1;
                    if (!within_tol(cnt_q, HALF_PERIOD)) begin
                        period_err_d = 1'b1;
                        state_d      = ACQ;
                    end
                end else begin
                    seen_d = seen_q | pulse_in;
                    if (cnt_d == SAT) begin
                        stall_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d  = (state_d == LOCKED);
        edge_d    = edge_c;
        err_cnt_d = err_cnt_q;
        if ((period_err_d | pulse_err_d | miss_err_d | stall_err_d) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk50) begin
        if (!rst) begin
            state_q      <= IDLE;
            clk1_q       <= clk1_in;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            locked_q     <= 1'b0;
            edge_q       <= 1'b0;
            meas_q       <= '0;
            period_err_q <= 1'b0;
            pulse_err_q  <= 1'b0;
            miss_err_q   <= 1'b0;
            stall_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            clk1_q       <= clk1_in;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            locked_q     <= locked_d;
            edge_q       <= edge_d;
            meas_q       <= meas_d;
            period_err_q <= period_err_d;
            pulse_err_q  <= pulse_err_d;
            miss_err_q   <= miss_err_d;
            stall_err_q  <= stall_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked           = locked_q;
    assign clk1_edge        = edge_q;
    assign half_period_meas = meas_q;
    assign period_err       = period_err_q;
    assign pulse_err        = pulse_err_q;
    assign miss_err         = miss_err_q;
    assign stall_err        = stall_err_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_div_monitor.sv
// Directed bench for div_monitor with HALF_PERIOD=26, PULSE_OFFSET=16, TOL=0.
// Each interval call starts with a clk1_in toggle; pulse index i lands where cnt = i.
module tb_div_monitor;

    localparam int unsigned HP  = 26;
    localparam int unsigned PO  = 16;
    localparam int unsigned TOL = 0;
    localparam int unsigned W   = $clog2(HP + TOL + 2);

    logic         clk50    = 1'b0;
    logic         rst      = 1'b0;
    logic         clk1_in  = 1'b1;
    logic         pulse_in = 1'b0;
    logic         locked;
    logic         clk1_edge;
    logic [W-1:0] half_period_meas;
    logic         period_err, pulse_err, miss_err, stall_err;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;
    int n_edge, n_period, n_pulse, n_miss, n_stall, n_both;

    always #5 clk50 = ~clk50;

    div_monitor #(
        .HALF_PERIOD (HP),
        .PULSE_OFFSET(PO),
        .TOL         (TOL)
    ) dut (
        .clk50           (clk50),
        .rst             (rst),
        .clk1_in         (clk1_in),
        .pulse_in        (pulse_in),
        .locked          (locked),
        .clk1_edge       (clk1_edge),
        .half_period_meas(half_period_meas),
        .period_err      (period_err),
        .pulse_err       (pulse_err),
        .miss_err        (miss_err),
        .stall_err       (stall_err),
        .err_cnt         (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("check %s: got %0d, expected %0d, ok", tag, actual, expected);
        end
    endtask

    task automatic clr();
        n_edge = 0; n_period = 0; n_pulse = 0; n_miss = 0; n_stall = 0; n_both = 0;
    endtask

    // Drive one cycle's inputs at a falling edge and collect strobes on the next falling edge.
    task automatic tick(input logic c1, input logic p);
        clk1_in  = c1;
        pulse_in = p;
        @(negedge clk50);
        n_edge   += int'(clk1_edge);
        n_period += int'(period_err);
        n_pulse  += int'(pulse_err);
        n_miss   += int'(miss_err);
        n_stall  += int'(stall_err);
        n_both   += int'(period_err & pulse_err);
    endtask

    task automatic interval(input int len, input int pa, input int pb, input bit all_p);
        for (int i = 0; i < len; i++)
            tick((i == 0) ? ~clk1_in : clk1_in, all_p || i == pa || i == pb);
    endtask

    initial begin
        clr();
        @(negedge clk50);

        // Reset with clk1_in high, then release: no spurious edge
        rst = 1'b0;
        repeat (3) tick(1'b1, 1'b0);
        check("rst_locked", locked, 0);
        check("rst_edge", clk1_edge, 0);
        check("rst_meas", half_period_meas, 0);
        check("rst_errs", {period_err, pulse_err, miss_err, stall_err}, 0);
        check("rst_errcnt", err_cnt, 0);
        rst = 1'b1;
        clr();
        tick(1'b1, 1'b0);
        check("release_no_edge", n_edge, 0);

        // Ideal source
        clr();
        interval(26, 16, -1, 0);
        check("ideal_unlocked_after_edge1", locked, 0);
        interval(26, 16, -1, 0);
        check("ideal_locked_after_edge2", locked, 1);
        interval(26, 16, -1, 0);
        interval(26, 16, -1, 0);
        check("ideal_edges", n_edge, 4);
        check("ideal_meas", half_period_meas, 26);
        check("ideal_errs", n_period + n_pulse + n_miss + n_stall, 0);
        check("ideal_errcnt", err_cnt, 0);

        // Short interval of 25; its closing edge also carries a bad pulse
        clr();
        interval(25, 16, -1, 0);
        interval(26, 0, 16, 0);
        check("short_unlocked", locked, 0);
        check("short_meas", half_period_meas, 25);
        check("short_period_err", n_period, 1);
        check("short_both_same_cycle", n_both, 1);
        check("short_errcnt_once", err_cnt, 1);
        interval(26, 16, -1, 0);
        check("short_relocked", locked, 1);
        check("short_no_miss", n_miss, 0);

        // Pulse at offset 17
        clr();
        interval(26, 17, -1, 0);
        check("late_pulse_err", n_pulse, 1);
        // Omitted pulse: miss flagged on the closing edge
        interval(26, -1, -1, 0);
        check("late_no_miss", n_miss, 0);
        interval(26, 16, -1, 0);
        check("omit_miss_err", n_miss, 1);
        // Two pulses in one interval
        interval(26, 16, 20, 0);
        check("double_pulse_err", n_pulse, 2);
        // Pulse only on the closing edge counts for the ending interval
        interval(26, -1, -1, 0);
        check("edge_pulse_prev_no_miss", n_miss, 1);
        interval(26, 0, 16, 0);
        check("edge_pulse_no_miss", n_miss, 1);
        check("edge_pulse_offset_err", n_pulse, 3);
        check("pulse_still_locked", locked, 1);
        check("pulse_period_clean", n_period, 0);
        check("pulse_errcnt", err_cnt, 5);

        // Stall: clk1_in held after a full interval
        clr();
        repeat (5) tick(clk1_in, 1'b0);
        check("stall_err", n_stall, 1);
        check("stall_unlocked", locked, 0);
        check("stall_errcnt", err_cnt, 6);

        // Saturate err_cnt with a pulse every cycle while locked
        clr();
        interval(26, 16, -1, 0);
        for (int k = 0; k < 13; k++)
            interval(26, -1, -1, 1);
        check("sat_locked", locked, 1);
        check("sat_errcnt", err_cnt, 255);
        check("sat_no_miss", n_miss, 0);

        // Reset mid-interval
        interval(10, -1, -1, 0);
        clr();
        rst = 1'b0;
        repeat (3) tick(~clk1_in, 1'b1);
        check("midrst_outputs", {locked, clk1_edge, period_err, pulse_err, miss_err, stall_err}, 0);
        check("midrst_meas", half_period_meas, 0);
        check("midrst_errcnt", err_cnt, 0);
        rst = 1'b1;
        repeat (30) tick(clk1_in, 1'b0);
        check("midrst_no_strobes", n_edge + n_period + n_pulse + n_miss + n_stall, 0);
        check("midrst_still_idle", locked, 0);
        check("midrst_errcnt_after", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_monitor.md
DIV_MONITOR -- requirements
Module: div_monitor

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 35_000_001, meaning the expected clk50 cycles between consecutive clk1 toggles.
REQ-002 The block SHALL have parameter PULSE_OFFSET, default 25_000_001, meaning the expected clk50 cycles from a clk1 toggle to the following pulse.
REQ-003 The block SHALL have parameter TOL, default 0, meaning the allowed +/- deviation in cycles for both checks.
REQ-004 The block SHALL derive W = ceil(log2(HALF_PERIOD+TOL+2)) as the counter and measurement width.
REQ-005 clk50  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low: rst=0 at a clk50 rising edge resets the block.
REQ-007 clk1_in  input  1  divided clock under test, synchronous to clk50.
REQ-008 pulse_in  input  1  one-cycle trigger pulse under test, synchronous to clk50.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 edge  output  1  one-cycle strobe on each detected clk1_in toggle.
REQ-011 half_period_meas  output  W  last measured toggle interval.
REQ-012 period_err / pulse_err / miss_err / stall_err  output  1 each  one-cycle error strobes.
REQ-013 err_cnt  output  8  saturating count of error cycles.

Function
REQ-014 Edge detection SHALL compare clk1_in with registered copy clk1_q; edge=1 in cycle t when they differ, so edge lags the toggle by 0 cycles and is registered out 1 cycle later.
REQ-015 Interval counter cnt SHALL load 1 on an edge cycle, otherwise increment, saturating at HALF_PERIOD+TOL+1.
REQ-016 On an edge, measured interval SHALL be the pre-update cnt; half_period_meas SHALL take it on every edge in ACQ or LOCKED.
REQ-017 FSM states SHALL be IDLE, ACQ, LOCKED.
REQ-018 IDLE -> ACQ on first edge; no measurement taken.
REQ-019 ACQ -> LOCKED on an edge with |measured-HALF_PERIOD| <= TOL; otherwise stay ACQ, no error flagged.
REQ-020 LOCKED: edge with measured out of tolerance SHALL assert period_err and go to ACQ.
REQ-021 In ACQ or LOCKED, cnt reaching saturation SHALL go to IDLE; stall_err SHALL assert only if leaving LOCKED.
REQ-022 Pulse offset SHALL be cnt in the pulse_in cycle; a pulse on an edge cycle belongs to the interval just ending (offset = measured).
REQ-023 In LOCKED, pulse_in with |offset-PULSE_OFFSET| > TOL, or a second pulse in one interval, SHALL assert pulse_err.
REQ-024 In LOCKED, an edge ending an interval with no pulse_in seen SHALL assert miss_err; pulse-seen flag clears on every edge.
REQ-025 The interval that enters LOCKED SHALL not be checked for miss_err; checking starts with the first full interval inside LOCKED.
REQ-026 Pulses in IDLE or ACQ SHALL be ignored.
REQ-027 Simultaneous errors SHALL each assert their own strobe; err_cnt SHALL increment by exactly 1 per cycle with any error and hold at 255.
REQ-028 All error strobes SHALL be registered, valid the cycle after the causing input cycle.

Reset
REQ-029 While rst=0: state IDLE, cnt=0, pulse-seen flag=0, clk1_q <= clk1_in (no spurious edge after release), and locked, edge, half_period_meas, all error strobes, and err_cnt SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL abandon the current interval with no error strobe generated.

Verification (HALF_PERIOD=26, PULSE_OFFSET=16, TOL=0)
REQ-031 Ideal source (toggle every 26, pulse 16 after each toggle) -> locked=1 after second edge, no errors, half_period_meas=26.
REQ-032 Locked, one interval of 25 -> period_err once, locked falls, relocks after next good interval, err_cnt=1.
REQ-033 Locked, pulse at offset 17 -> pulse_err one cycle; pulse omitted -> miss_err on next edge; two pulses -> pulse_err on second.
REQ-034 Locked, clk1_in held constant -> stall_err when cnt hits 27, state IDLE, locked=0.
REQ-035 Force 300 error cycles -> err_cnt saturates at 255; rst=0 mid-interval -> all outputs 0, no strobe.
REQ-036 clk1_in=1 during reset release -> no edge strobe in the first cycle.
